shared_spill_arbiter: RTL

SHARED_SPILL_ARBITER -- requirements
Module: shared_spill_arbiter

---
 rtl/shared_spill_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/shared_spill_arbiter.sv
// Round-robin N:1 arbiter feeding a 2-entry spill buffer. Every output is
// driven from registered state (ready_o also looks at valid_i), so no path runs from ready_i to any ready_o.
module shared_spill_arbiter #(
  parameter int WIDTH  = 1,
  parameter int NUM_IN = 4,
  localparam int IDX_W = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [NUM_IN-1:0]         valid_i,
  output logic [NUM_IN-1:0]         ready_o,
  input  logic [NUM_IN*WIDTH-1:0]   data_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [WIDTH-1:0]          data_o,
  output logic [IDX_W-1:0]          idx_o
);

  logic [1:0]       count;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant;
  logic             found;
  logic             space;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] tail_data;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic [WIDTH-1:0] in_data;

  // Scan from the farthest offset down so the one closest to ptr wins.
  always_comb begin
    int k;
    k     = 0;
    found = 1'b0;
    grant = '0;
    for (int off = NUM_IN - 1; off >= 0; off--) begin
      k = int'(ptr) + off;
      if (k >= NUM_IN) k = k - NUM_IN;
      if (valid_i[k]) begin
        found = 1'b1;
        grant = IDX_W'(k);
      end
    end
  end

  // A full buffer refuses pushes even if it is popping this cycle.
  assign space = (count < 2'd2) && !flush_i && !rst_i;
  assign push  = found && space;
  assign pop   = (count != 2'd0) && ready_i && !flush_i;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign ready_o[gi] = push && (grant == IDX_W'(gi));
    end
  endgenerate

  assign in_data = data_i[int'(grant)*WIDTH +: WIDTH];

  assign valid_o = (count != 2'd0);
  assign data_o  = head_data;
  assign idx_o   = head_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count     <= 2'd0;
      ptr       <= '0;
      head_data <= '0;
      head_idx  <= '0;
      tail_data <= '0;
      tail_idx  <= '0;
    end else if (flush_i) begin
      count <= 2'd0;
    end else begin
      if (push) begin
        ptr <= (grant == IDX_W'(NUM_IN - 1)) ? '0 : grant + IDX_W'(1);
      end
      // push+pop can only coincide at count 1: the new entry becomes head.
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_data <= in_data;
            head_idx  <= grant;
          end else begin
            tail_data <= in_data;
            tail_idx  <= grant;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_idx  <= tail_idx;
          count     <= count - 2'd1;
        end
        2'b11: begin
          head_data <= in_data;
          head_idx  <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule
